// File: rtl/binary_to_one_hot_pkg.sv
// rtl/binary_to_one_hot_pkg.sv - shared constants for the pipelined binary-to-one-hot decoder
// Contents:
//   BUF_EMPTY / BUF_HALF / BUF_FULL : occupancy states of the 2-entry skid buffer
//   index_width()                   : width of the decode index (one bit wider than the input)
package binary_to_one_hot_pkg;

    localparam logic [1:0] BUF_EMPTY = 2'd0;
    localparam logic [1:0] BUF_HALF  = 2'd1;
    localparam logic [1:0] BUF_FULL  = 2'd2;

    // Extra bit keeps binary_in - BASE_VALUE from wrapping.
    function automatic int index_width(input int binary_width);
        return binary_width + 1;
    endfunction

endpackage

// File: rtl/skid_buffer_2entry.sv
// rtl/skid_buffer_2entry.sv - 2-entry skid buffer with registered ready
// Ports:
//   clock, clear             : clock, asynchronous active-high reset
//   in_tvalid/in_tready/in_tdata    : upstream handshake (in_tready is a flop)
//   out_tvalid/out_tready/out_tdata : downstream handshake (out_tdata held while stalled)
module skid_buffer_2entry
    import binary_to_one_hot_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [WIDTH-1:0] out_tdata
);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] skid_tdata;
    logic             push;
    logic             pop;

    assign push = in_tvalid & in_tready;
    assign pop  = out_tvalid & out_tready;

    always_comb begin
        next_state = state;
        case (state)
            BUF_EMPTY: if (push) next_state = BUF_HALF;
            BUF_HALF: begin
                if (push && !pop)      next_state = BUF_FULL;
                else if (!push && pop) next_state = BUF_EMPTY;
            end
            BUF_FULL:  if (pop) next_state = BUF_HALF;
            default:   next_state = BUF_EMPTY;
        endcase
    end

    // Ready and valid are derived from the next state so both are plain flops;
    // out_tready never reaches in_tready combinationally.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= BUF_EMPTY;
            in_tready  <= 1'b1;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            skid_tdata <= '0;
        end else begin
            state      <= next_state;
            in_tready  <= (next_state != BUF_FULL);
            out_tvalid <= (next_state != BUF_EMPTY);
            case (state)
                BUF_EMPTY: if (push) out_tdata <= in_tdata;
                BUF_HALF: begin
                    if (push && pop) out_tdata  <= in_tdata;
                    else if (push)   skid_tdata <= in_tdata;
                end
                BUF_FULL:  if (pop) out_tdata <= skid_tdata;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/binary_to_one_hot_pipelined.sv
// rtl/binary_to_one_hot_pipelined.sv - registered, flow-controlled binary-to-one-hot decoder
// Ports:
//   clock, clear                       : clock, asynchronous active-high reset
//   binary_in_valid/ready, binary_in   : input handshake and value (ready is registered)
//   one_hot_out_valid/ready            : output handshake
//   one_hot_out, out_of_range          : decoded vector and window-miss flag
//   thermometer_in                     : only with BINARY_TO_ONE_HOT_THERMOMETER_EN; selects
//                                        thermometer fill [index:0] instead of a single bit
module binary_to_one_hot_pipelined
    import binary_to_one_hot_pkg::*;
#(
    parameter int BINARY_WIDTH = 4,
    parameter int OUTPUT_WIDTH = 16,
    parameter int BASE_VALUE   = 0
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    binary_in_valid,
    output logic                    binary_in_ready,
    input  logic [BINARY_WIDTH-1:0] binary_in,
`ifdef BINARY_TO_ONE_HOT_THERMOMETER_EN
    input  logic                    thermometer_in,
`endif
    output logic                    one_hot_out_valid,
    input  logic                    one_hot_out_ready,
    output logic [OUTPUT_WIDTH-1:0] one_hot_out,
    output logic                    out_of_range
);

    localparam int IW = index_width(BINARY_WIDTH);
    localparam logic [BINARY_WIDTH-1:0] BASE_B = BASE_VALUE[BINARY_WIDTH-1:0];
    localparam logic [31:0] OW = 32'(OUTPUT_WIDTH);

    logic                    therm;
    logic [IW-1:0]           index;
    logic [31:0]             index32;
    logic                    below;
    logic                    above;
    logic [OUTPUT_WIDTH-1:0] decoded;
    logic [OUTPUT_WIDTH:0]   buf_out;

`ifdef BINARY_TO_ONE_HOT_THERMOMETER_EN
    assign therm = thermometer_in;
`else
    assign therm = 1'b0;
`endif

    always_comb begin
        below   = (binary_in < BASE_B);
        index   = {1'b0, binary_in} - {1'b0, BASE_B};
        index32 = 32'(index);
        above   = !below && (index32 >= OW);
        decoded = '0;
        for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
            decoded[i] = therm ? (i <= index32) : (i == index32);
        end
        // Above the window a thermometer saturates; a one-hot goes dark.
        if (below)      decoded = '0;
        else if (above) decoded = therm ? '1 : '0;
    end

    skid_buffer_2entry #(
        .WIDTH (OUTPUT_WIDTH + 1)
    ) u_buf (
        .clock      (clock),
        .clear      (clear),
        .in_tvalid  (binary_in_valid),
        .in_tready  (binary_in_ready),
        .in_tdata   ({decoded, below | above}),
        .out_tvalid (one_hot_out_valid),
        .out_tready (one_hot_out_ready),
        .out_tdata  (buf_out)
    );

    assign one_hot_out  = buf_out[OUTPUT_WIDTH:1];
    assign out_of_range = buf_out[0];

endmodule
